// File: rtl/universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_n
//
// Purpose:
//   A WIDTH-bit universal shift register. It can hold, shift left or right
//   with a serial input, rotate left or right, load a parallel word, or clear.
//   A shift counter follows the position inside a WIDTH-shift "word". On the
//   cycle in which the WIDTH-th shifted word becomes visible, a single-cycle
//   WordDone pulse is raised.
//
// Parameters:
//   WIDTH      register width in bits (2..32)
//   RESET_VAL  register contents after reset
//   CW         shift-counter width, derived from WIDTH (do not override)
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset_n      in   asynchronous active-low reset
//   Mode[2:0]    in   000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                     101 load, 110 clear, 111 hold
//   SerInL       in   bit entering at bit 0 on shift-left
//   SerInR       in   bit entering at bit WIDTH-1 on shift-right
//   ParallelIn   in   load word for mode 101
//   ParallelOut  out  current register contents
//   SerOutL      out  ParallelOut[WIDTH-1]
//   SerOutR      out  ParallelOut[0]
//   ShiftCount   out  shift/rotate ops taken in the current word
//   WordDone     out  registered pulse, high for the cycle after the
//                     WIDTH-th shift op of a word
// -----------------------------------------------------------------------------
module universal_shift_reg_n #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [2:0]       Mode,
    input  logic             SerInL,
    input  logic             SerInR,
    input  logic [WIDTH-1:0] ParallelIn,
    output logic [WIDTH-1:0] ParallelOut,
    output logic             SerOutL,
    output logic             SerOutR,
    output logic [CW-1:0]    ShiftCount,
    output logic             WordDone
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] dataReg;
    logic [WIDTH-1:0] dataNext;
    logic [CW-1:0]    countReg;
    logic [CW-1:0]    countNext;
    logic             doneReg;
    logic             doneNext;
    logic             isShiftOp;

    // Candidate words for the four shift ops. Each one is built bit by bit,
    // so the end bits (serial input or wrap-around) can be seen directly.
    logic [WIDTH-1:0] shlWord;
    logic [WIDTH-1:0] shrWord;
    logic [WIDTH-1:0] rolWord;
    logic [WIDTH-1:0] rorWord;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gBit
            if (gi == 0) begin : gLsb
                assign shlWord[gi] = SerInL;
                assign rolWord[gi] = dataReg[WIDTH-1];
            end else begin : gUpper
                assign shlWord[gi] = dataReg[gi-1];
                assign rolWord[gi] = dataReg[gi-1];
            end

            if (gi == WIDTH - 1) begin : gMsb
                assign shrWord[gi] = SerInR;
                assign rorWord[gi] = dataReg[0];
            end else begin : gLower
                assign shrWord[gi] = dataReg[gi+1];
                assign rorWord[gi] = dataReg[gi+1];
            end
        end
    endgenerate

    // Next register contents. Modes 000 and 111 keep the default (hold).
    always_comb begin
        dataNext  = dataReg;
        isShiftOp = 1'b0;
        case (Mode)
            MODE_SHL: begin
                dataNext  = shlWord;
                isShiftOp = 1'b1;
            end
            MODE_SHR: begin
                dataNext  = shrWord;
                isShiftOp = 1'b1;
            end
            MODE_ROL: begin
                dataNext  = rolWord;
                isShiftOp = 1'b1;
            end
            MODE_ROR: begin
                dataNext  = rorWord;
                isShiftOp = 1'b1;
            end
            MODE_LOAD:  dataNext = ParallelIn;
            MODE_CLEAR: dataNext = '0;
            default:    dataNext = dataReg;
        endcase
    end

    // Word tracking. All four shift ops advance the same counter, so a change
    // of direction mid-word does not restart it. Load and clear abort the
    // word. Hold keeps the count. WordDone is driven only by the wrapping
    // shift op, so the pulse lasts one cycle and never stretches across
    // hold cycles.
    always_comb begin
        countNext = countReg;
        doneNext  = 1'b0;
        if (isShiftOp) begin
            if (countReg == LAST_COUNT) begin
                countNext = '0;
                doneNext  = 1'b1;
            end else begin
                countNext = countReg + CW'(1);
            end
        end else if ((Mode == MODE_LOAD) || (Mode == MODE_CLEAR)) begin
            countNext = '0;
        end else if (Mode == MODE_HOLD) begin
            countNext = countReg;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dataReg  <= RESET_VAL;
            countReg <= '0;
            doneReg  <= 1'b0;
        end else begin
            dataReg  <= dataNext;
            countReg <= countNext;
            doneReg  <= doneNext;
        end
    end

    // Every output comes straight from a register. No input reaches an
    // output without passing through a flop first.
    assign ParallelOut = dataReg;
    assign SerOutL     = dataReg[WIDTH-1];
    assign SerOutR     = dataReg[0];
    assign ShiftCount  = countReg;
    assign WordDone    = doneReg;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg_n
//
// Bench for universal_shift_reg_n with WIDTH=4 and RESET_VAL=0.
//
// The driver works on falling clock edges. Each time it applies a mode, it
// advances an arithmetic reference model and pushes the outputs expected
// after the next rising edge. A reset assertion pushes the reset values
// expected right away and again on the following edge. A separate monitor
// wakes after each rising clock edge or falling Reset_n edge, pops one
// expectation, and compares every output.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg_n;

    localparam int W = 4;

    logic         Clk;
    logic         Reset_n;
    logic [2:0]   Mode;
    logic         SerInL;
    logic         SerInR;
    logic [W-1:0] ParallelIn;
    logic [W-1:0] ParallelOut;
    logic         SerOutL;
    logic         SerOutR;
    logic [1:0]   ShiftCount;
    logic         WordDone;

    universal_shift_reg_n #(
        .WIDTH     (W),
        .RESET_VAL (4'b0000)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Mode        (Mode),
        .SerInL      (SerInL),
        .SerInR      (SerInR),
        .ParallelIn  (ParallelIn),
        .ParallelOut (ParallelOut),
        .SerOutL     (SerOutL),
        .SerOutR     (SerOutR),
        .ShiftCount  (ShiftCount),
        .WordDone    (WordDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int po;
        int cnt;
        int done;
        int id;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state. It holds the register as an integer and the
    // number of shift ops taken in the current word.
    int mdlVal  = 0;
    int mdlCnt  = 0;
    int mdlDone = 0;

    task automatic check(input string name, input int act, input int req, input int id);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%0d required=%0d", name, id, act, req);
        end
    endtask

    task automatic model_apply(input int mode, input int sl, input int sr, input int pin);
        int top;
        int mask;
        top  = 1 << (W - 1);
        mask = (1 << W) - 1;
        case (mode)
            1: mdlVal = ((mdlVal * 2) + sl) & mask;
            2: mdlVal = (mdlVal / 2) + sr * top;
            3: mdlVal = ((mdlVal * 2) & mask) + (mdlVal / top);
            4: mdlVal = (mdlVal / 2) + (mdlVal % 2) * top;
            5: mdlVal = pin;
            6: mdlVal = 0;
            default: ;
        endcase
        if (mode >= 1 && mode <= 4) begin
            mdlCnt  = (mdlCnt + 1) % W;
            mdlDone = (mdlCnt == 0) ? 1 : 0;
        end else begin
            if (mode == 5 || mode == 6) mdlCnt = 0;
            mdlDone = 0;
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.po   = mdlVal;
        e.cnt  = mdlCnt;
        e.done = mdlDone;
        e.id   = txn;
        expQ.push_back(e);
    endtask

    // One normal operation, applied on the next rising edge.
    task automatic step(input int mode, input int sl, input int sr, input int pin);
        @(negedge Clk);
        Reset_n    = 1'b1;
        Mode       = 3'(mode);
        SerInL     = 1'(sl);
        SerInR     = 1'(sr);
        ParallelIn = 4'(pin);
        txn++;
        model_apply(mode, sl, sr, pin);
        $display("txn %0d: mode=%0d sl=%0d sr=%0d pin=%0d -> exp po=%0d cnt=%0d done=%0d",
                 txn, mode, sl, sr, pin, mdlVal, mdlCnt, mdlDone);
        push_model();
    endtask

    // Reset asserted half a cycle away from the rising edge. One expectation
    // covers the immediate response and one covers the edge that follows.
    task automatic assert_reset();
        @(negedge Clk);
        txn++;
        mdlVal  = 0;
        mdlCnt  = 0;
        mdlDone = 0;
        $display("txn %0d: async reset asserted", txn);
        push_model();
        push_model();
        Reset_n = 1'b0;
    endtask

    // A cycle spent in reset with random inputs. The outputs must not move.
    task automatic reset_cycle();
        @(negedge Clk);
        txn++;
        Mode       = 3'($urandom_range(0, 7));
        SerInL     = 1'($urandom_range(0, 1));
        SerInR     = 1'($urandom_range(0, 1));
        ParallelIn = 4'($urandom_range(0, 15));
        $display("txn %0d: in reset, mode=%0d", txn, Mode);
        push_model();
    endtask

    // A direct check of a value stated outright for a directed scenario.
    task automatic direct_check(input string name, input int po, input int done);
        @(posedge Clk);
        #2;
        check({name, "_po"}, int'(ParallelOut), po, txn);
        check({name, "_done"}, int'(WordDone), done, txn);
    endtask

    // Monitor: one expectation per rising clock edge or reset assertion.
    initial begin
        forever begin
            @(posedge Clk or negedge Reset_n);
            #1;
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                check("ParallelOut", int'(ParallelOut), e.po, e.id);
                check("SerOutL", int'(SerOutL), (e.po >> (W - 1)) & 1, e.id);
                check("SerOutR", int'(SerOutR), e.po & 1, e.id);
                check("ShiftCount", int'(ShiftCount), e.cnt, e.id);
                check("WordDone", int'(WordDone), e.done, e.id);
            end
        end
    end

    initial begin
        Reset_n    = 1'b0;
        Mode       = 3'b000;
        SerInL     = 1'b0;
        SerInR     = 1'b0;
        ParallelIn = '0;

        reset_cycle();
        reset_cycle();

        // SIPO: 1,0,1,1 shifted in gives 1011 together with the word pulse.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        direct_check("sipo", 4'b1011, 1);

        // PISO by rotation: load 1001, rotate right 4 times, back to 1001.
        step(5, 1, 1, 4'b1001);
        for (int i = 0; i < 4; i++) step(4, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
        direct_check("piso", 4'b1001, 1);

        // Abort: 3 shift-rights, clear, then 4 more shifts.
        for (int i = 0; i < 3; i++) step(2, 0, 1, 0);
        step(6, 1, 1, 15);
        for (int i = 0; i < 4; i++) step(2, 0, $urandom_range(0, 1), 0);

        // Hold and mixed direction, including reserved mode 7.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step((i == 2) ? 7 : 0, 1, 1, 9);
        step(4, 0, 0, 0);
        step(4, 0, 0, 0);

        // Continuous shifting with a reset after the sixth edge.
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 1), 0, 0);
        assert_reset();
        reset_cycle();
        for (int i = 0; i < 12; i++) step(1, $urandom_range(0, 1), 0, 0);

        // Random operations with an occasional asynchronous reset.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                assert_reset();
                if ($urandom_range(0, 1) == 1) reset_cycle();
            end else begin
                step($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 15));
            end
        end

        @(negedge Clk);
        @(negedge Clk);
        check("queue_drained", expQ.size(), 0, txn);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
